// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - k-slice skew feeder and start-code sequencer for an NxN systolic array
module systolic_skew_feeder #(
  parameter int DATAWIDTH = 8,
  parameter int N         = 4,
  parameter int K         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATAWIDTH-1:0] a_vec,
  input  logic [N*DATAWIDTH-1:0] b_vec,
  output logic [N*DATAWIDTH-1:0] a_edge,
  output logic [N*DATAWIDTH-1:0] b_edge,
  output logic [1:0]             start,
  output logic                   busy,
  output logic                   done
);

  localparam int BW = $clog2(K + 1);
  localparam int FW = $clog2(2 * N);

  localparam logic [1:0] START_COMPUTE = 2'b00;
  localparam logic [1:0] START_OUTPUT  = 2'b10;
  localparam logic [1:0] START_HOLD    = 2'b11;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] beat_cnt, beat_cnt_nx;
  logic [FW-1:0] flush_cnt, flush_cnt_nx;
  logic [1:0]    start_nx;
  logic          accept;

  assign in_ready = rst && (state == IDLE || state == FEED);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx     = state;
    beat_cnt_nx  = beat_cnt;
    flush_cnt_nx = flush_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          beat_cnt_nx  = BW'(1);
          flush_cnt_nx = '0;
          state_nx     = (K == 1) ? FLUSH : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          beat_cnt_nx = beat_cnt + BW'(1);
          if (beat_cnt == BW'(K - 1)) begin
            state_nx     = FLUSH;
            flush_cnt_nx = '0;
          end
        end
      end
      FLUSH: begin
        // 2N-1 cycles lets the last element cross to pe(N-1,N-1)
        if (flush_cnt == FW'(2 * N - 2)) state_nx = DRAIN;
        else flush_cnt_nx = flush_cnt + FW'(1);
      end
      default: begin
        state_nx     = IDLE;
        beat_cnt_nx  = '0;
        flush_cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    start_nx = START_HOLD;
    case (state_nx)
      FEED, FLUSH: start_nx = START_COMPUTE;
      DRAIN:       start_nx = START_OUTPUT;
      default:     start_nx = START_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      start     <= START_HOLD;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      beat_cnt  <= beat_cnt_nx;
      flush_cnt <= flush_cnt_nx;
      start     <= start_nx;
      done      <= (state == DRAIN);
    end
  end

  // Lane i is delayed i+1 cycles; non-accept cycles inject zero bubbles
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATAWIDTH-1:0] a_pipe [i+1];
    logic [DATAWIDTH-1:0] b_pipe [i+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= i; s++) begin
          a_pipe[s] <= '0;
          b_pipe[s] <= '0;
        end
      end else begin
        a_pipe[0] <= accept ? a_vec[i*DATAWIDTH +: DATAWIDTH] : '0;
        b_pipe[0] <= accept ? b_vec[i*DATAWIDTH +: DATAWIDTH] : '0;
        for (int s = 1; s <= i; s++) begin
          a_pipe[s] <= a_pipe[s-1];
          b_pipe[s] <= b_pipe[s-1];
        end
      end
    end

    assign a_edge[i*DATAWIDTH +: DATAWIDTH] = a_pipe[i];
    assign b_edge[i*DATAWIDTH +: DATAWIDTH] = b_pipe[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed bench for systolic_skew_feeder with a 2x2 pe array model
module tb_systolic_skew_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // u2: N=2,K=2   u1: N=2,K=1   u4: N=4,K=4
  logic        iv2, ir2, busy2, done2;
  logic [15:0] a2, b2, ae2, be2;
  logic [1:0]  st2;
  logic        iv1, ir1, busy1, done1;
  logic [15:0] a1, b1, ae1, be1;
  logic [1:0]  st1;
  logic        iv4, ir4, busy4, done4;
  logic [31:0] a4, b4, ae4, be4;
  logic [1:0]  st4;

  systolic_skew_feeder #(.DATAWIDTH(8), .N(2), .K(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a_vec(a2), .b_vec(b2),
    .a_edge(ae2), .b_edge(be2), .start(st2), .busy(busy2), .done(done2));
  systolic_skew_feeder #(.DATAWIDTH(8), .N(2), .K(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a_vec(a1), .b_vec(b1),
    .a_edge(ae1), .b_edge(be1), .start(st1), .busy(busy1), .done(done1));
  systolic_skew_feeder #(.DATAWIDTH(8), .N(4), .K(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a_vec(a4), .b_vec(b4),
    .a_edge(ae4), .b_edge(be4), .start(st4), .busy(busy4), .done(done4));

  // 2x2 pe arrays behind u2 (index 0) and u1 (index 1); cleared after each drain
  logic [15:0] m_ea [2];
  logic [15:0] m_eb [2];
  logic [1:0]  m_st [2];
  logic [7:0]  m_ain [2][2][2];
  logic [7:0]  m_bin [2][2][2];
  logic [7:0]  m_a   [2][2][2];
  logic [7:0]  m_b   [2][2][2];
  int          m_acc [2][2][2];
  int          m_out [2][2][2];

  assign m_ea[0] = ae2;
  assign m_ea[1] = ae1;
  assign m_eb[0] = be2;
  assign m_eb[1] = be1;
  assign m_st[0] = st2;
  assign m_st[1] = st1;

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 2; i++) begin
        m_ain[u][i][0] = m_ea[u][i*8 +: 8];
        m_ain[u][i][1] = m_a[u][i][0];
        m_bin[u][0][i] = m_eb[u][i*8 +: 8];
        m_bin[u][1][i] = m_b[u][0][i];
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          if (!rst) begin
            m_a[u][i][j]   <= '0;
            m_b[u][i][j]   <= '0;
            m_acc[u][i][j] <= 0;
            m_out[u][i][j] <= 0;
          end else if (m_st[u] == 2'b00) begin
            m_acc[u][i][j] <= m_acc[u][i][j] + int'(m_ain[u][i][j]) * int'(m_bin[u][i][j]);
            m_a[u][i][j]   <= m_ain[u][i][j];
            m_b[u][i][j]   <= m_bin[u][i][j];
          end else if (m_st[u] == 2'b10) begin
            m_out[u][i][j] <= m_acc[u][i][j];
            m_acc[u][i][j] <= 0;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick;
    n_checks++; if (st2 !== 2'b11) begin n_fail++; $display("FAIL reset_start: got %b want 11", st2); end
    n_checks++; if (ae2 !== 16'h0 || be2 !== 16'h0) begin n_fail++; $display("FAIL reset_edges: got %h/%h want 0/0", ae2, be2); end
    n_checks++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy2, done2); end
    n_checks++; if (ir2 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", ir2); end
    rst = 1'b1;
    #1;
    n_checks++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", ir2); end
    tick;
    iv2 = 1'b1; a2 = 16'h0201; b2 = 16'h0403;
    tick;
    iv2 = 1'b0;
    n_checks++; if (ae2 !== 16'h0001 || st2 !== 2'b00) begin n_fail++; $display("FAIL feed_before_reset: got %h/%b want 0001/00", ae2, st2); end
    rst = 1'b0;
    #1;
    n_checks++; if (ae2 !== 16'h0 || be2 !== 16'h0) begin n_fail++; $display("FAIL midreset_edges: got %h/%h want 0/0", ae2, be2); end
    n_checks++; if (st2 !== 2'b11 || busy2 !== 1'b0 || ir2 !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: got st=%b busy=%b rdy=%b want 11,0,0", st2, busy2, ir2); end
    tick;
    rst = 1'b1;
    #1;
    n_checks++; if (ir2 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL midreset_release: got rdy=%b busy=%b want 1,0", ir2, busy2); end
    tick;
  endtask

  task automatic test_product(input int gap);
    int t;
    bit seen;
    int e [4];
    logic [7:0] exp_l1;
    e = '{19, 22, 43, 50};
    iv2 = 1'b1; a2 = {8'd3, 8'd1}; b2 = {8'd6, 8'd5};
    tick; t = 1;
    n_checks++; if (ae2 !== 16'h0001 || be2 !== 16'h0005) begin n_fail++; $display("FAIL skew_beat0 gap%0d: got %h/%h want 0001/0005", gap, ae2, be2); end
    iv2 = 1'b0;
    repeat (gap) begin tick; t++; end
    iv2 = 1'b1; a2 = {8'd4, 8'd2}; b2 = {8'd8, 8'd7};
    tick; t++;
    iv2 = 1'b0;
    exp_l1 = (gap == 0) ? 8'd3 : 8'd0;
    n_checks++; if (ae2[7:0] !== 8'd2 || ae2[15:8] !== exp_l1) begin n_fail++; $display("FAIL skew_beat1 gap%0d: got %h want %h02", gap, ae2, exp_l1); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done2) seen = 1'b1;
      else begin tick; t++; end
    end
    n_checks++; if (!seen || t != 6 + gap) begin n_fail++; $display("FAIL done_latency gap%0d: got seen=%0d t=%0d want t=%0d", gap, seen, t, 6 + gap); end
    n_checks++; if (st2 !== 2'b11) begin n_fail++; $display("FAIL done_start gap%0d: got %b want 11", gap, st2); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (m_out[0][i][j] != e[i*2+j]) begin n_fail++; $display("FAIL pe_out gap%0d (%0d,%0d): got %0d want %0d", gap, i, j, m_out[0][i][j], e[i*2+j]); end
      end
    tick;
    n_checks++; if (done2 !== 1'b0) begin n_fail++; $display("FAIL done_pulse gap%0d: got %b want 0", gap, done2); end
  endtask

  task automatic test_timing;
    logic [1:0] exp_st;
    for (int b = 0; b < 4; b++) begin
      iv4 = 1'b1;
      a4 = {8'(13 + b), 8'(9 + b), 8'(5 + b), 8'(1 + b)};
      b4 = ~a4;
      tick;
      if (b == 0) begin
        n_checks++; if (ae4 !== 32'h0000_0001) begin n_fail++; $display("FAIL n4_skew_first: got %h want 00000001", ae4); end
      end
    end
    iv4 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      exp_st = (c <= 7) ? 2'b00 : ((c == 8) ? 2'b10 : 2'b11);
      n_checks++; if (st4 !== exp_st) begin n_fail++; $display("FAIL n4_start T+%0d: got %b want %b", c, st4, exp_st); end
      n_checks++; if (done4 !== (c == 9) || busy4 !== (c <= 8)) begin n_fail++; $display("FAIL n4_done_busy T+%0d: got %b%b want %b%b", c, done4, busy4, (c == 9), (c <= 8)); end
      if (c == 1) begin
        n_checks++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL n4_flush_ready: got %b want 0", ir4); end
      end
      if (c == 4) begin
        n_checks++; if (ae4[31:24] !== 8'd16 || be4[31:24] !== 8'hEF) begin n_fail++; $display("FAIL n4_lane3_last: got %h/%h want 10/ef", ae4[31:24], be4[31:24]); end
      end
      tick;
    end
  endtask

  task automatic test_k1;
    int t;
    bit seen;
    int e [4];
    e = '{8, 10, 12, 15};
    iv1 = 1'b1; a1 = {8'd3, 8'd2}; b1 = {8'd5, 8'd4};
    tick; t = 1;
    iv1 = 1'b0;
    n_checks++; if (ir1 !== 1'b0 || busy1 !== 1'b1 || st1 !== 2'b00) begin n_fail++; $display("FAIL k1_direct_flush: got rdy=%b busy=%b st=%b want 0,1,00", ir1, busy1, st1); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done1) seen = 1'b1;
      else begin tick; t++; end
    end
    n_checks++; if (!seen || t != 5) begin n_fail++; $display("FAIL k1_done_latency: got seen=%0d t=%0d want t=5", seen, t); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (m_out[1][i][j] != e[i*2+j]) begin n_fail++; $display("FAIL k1_pe_out (%0d,%0d): got %0d want %0d", i, j, m_out[1][i][j], e[i*2+j]); end
      end
    tick;
  endtask

  task automatic test_back_to_back;
    bit seen;
    int e1 [4];
    int e2 [4];
    e1 = '{19, 22, 43, 50};
    e2 = '{2, 3, 4, 5};
    iv2 = 1'b1; a2 = {8'd3, 8'd1}; b2 = {8'd6, 8'd5};
    tick;
    a2 = {8'd4, 8'd2}; b2 = {8'd8, 8'd7};
    tick;
    a2 = {8'd0, 8'd1}; b2 = {8'd3, 8'd2};
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done2) seen = 1'b1;
      else begin
        n_checks++; if (ir2 !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked cycle %0d: got in_ready=%b want 0", c, ir2); end
        tick;
      end
    end
    n_checks++; if (!seen || ir2 !== 1'b1) begin n_fail++; $display("FAIL b2b_done_ready: got seen=%0d rdy=%b want 1,1", seen, ir2); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (m_out[0][i][j] != e1[i*2+j]) begin n_fail++; $display("FAIL b2b_first (%0d,%0d): got %0d want %0d", i, j, m_out[0][i][j], e1[i*2+j]); end
      end
    tick;
    n_checks++; if (busy2 !== 1'b1 || ir2 !== 1'b1 || st2 !== 2'b00) begin n_fail++; $display("FAIL b2b_feed: got busy=%b rdy=%b st=%b want 1,1,00", busy2, ir2, st2); end
    a2 = {8'd1, 8'd0}; b2 = {8'd5, 8'd4};
    tick;
    iv2 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (done2) seen = 1'b1;
      else tick;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_second_done: got timeout want done"); end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        n_checks++;
        if (m_out[0][i][j] != e2[i*2+j]) begin n_fail++; $display("FAIL b2b_second (%0d,%0d): got %0d want %0d", i, j, m_out[0][i][j], e2[i*2+j]); end
      end
    tick;
  endtask

  initial begin
    iv2 = 1'b0; a2 = '0; b2 = '0;
    iv1 = 1'b0; a1 = '0; b1 = '0;
    iv4 = 1'b0; a4 = '0; b4 = '0;
    test_reset;
    test_product(0);
    test_product(3);
    test_timing;
    test_k1;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
